spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_target.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target bridging an external host to a CSR core byte interface.
// Pins are resynchronised into clk; all protocol state lives in the clk domain.
module spi_target #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_rdy,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  data_latch,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0] FILL_DONE = 2'd3;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    // synchronizer and edge-detect stages
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_mosi_s1, r_mosi_s2;
    logic [1:0] r_fill;

    // protocol state
    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic                  r_tx_pend;
    logic                  r_ur_arm;

    // registered outputs
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_data_rdy;
    logic                  r_tx_underrun;
    logic                  r_busy;
    logic                  r_miso_oe;
    logic                  r_miso;

    // next-state values
    logic [0:0]            w_state_nx;
    logic [CNT_W-1:0]      w_bit_cnt_nx;
    logic [DATA_WIDTH-2:0] w_rx_shift_nx;
    logic [DATA_WIDTH-1:0] w_tx_shift_nx;
    logic [DATA_WIDTH-1:0] w_tx_buf_nx;
    logic                  w_tx_pend_nx;
    logic                  w_ur_arm_nx;
    logic [DATA_WIDTH-1:0] w_data_in_nx;
    logic                  w_data_rdy_nx;
    logic                  w_tx_underrun_nx;
    logic                  w_busy_nx;
    logic                  w_miso_nx;
    logic                  w_load;

    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic [DATA_WIDTH-1:0] w_rx_full;

    // r_fill guards cs_n edge detection until every stage holds a real pin sample,
    // so a cs_n already low at reset release is not mistaken for a falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_fill    <= 2'd0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            if (r_fill != FILL_DONE) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_cs_fall   = (r_fill == FILL_DONE) & r_cs_s3 & ~r_cs_s2;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
    assign w_rx_full   = {r_rx_shift, r_mosi_s2};

    // Underrun is flagged when an empty byte starts shifting (its first rise),
    // so the reload after a frame's final byte stays silent.
    always_comb begin
        w_state_nx       = r_state;
        w_bit_cnt_nx     = r_bit_cnt;
        w_rx_shift_nx    = r_rx_shift;
        w_tx_shift_nx    = r_tx_shift;
        w_tx_buf_nx      = r_tx_buf;
        w_tx_pend_nx     = r_tx_pend;
        w_ur_arm_nx      = r_ur_arm;
        w_data_in_nx     = r_data_in;
        w_data_rdy_nx    = 1'b0;
        w_tx_underrun_nx = 1'b0;
        w_load           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nx    = S_ACTIVE;
                    w_bit_cnt_nx  = CNT_ZERO;
                    w_rx_shift_nx = '0;
                    w_load        = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nx    = S_IDLE;
                    w_bit_cnt_nx  = CNT_ZERO;
                    w_rx_shift_nx = '0;
                    w_tx_shift_nx = '0;
                    w_ur_arm_nx   = 1'b0;
                end else if (w_sclk_rise) begin
                    w_rx_shift_nx = w_rx_full[DATA_WIDTH-2:0];
                    if (r_ur_arm && (r_bit_cnt == CNT_ZERO)) begin
                        w_tx_underrun_nx = 1'b1;
                        w_ur_arm_nx      = 1'b0;
                    end
                    if (r_bit_cnt == LAST_BIT) begin
                        w_data_in_nx  = w_rx_full;
                        w_data_rdy_nx = 1'b1;
                        w_bit_cnt_nx  = CNT_ZERO;
                        w_load        = 1'b1;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + CNT_ONE;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != CNT_ZERO)) begin
                    w_tx_shift_nx = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // the load sees the old buffer; a same-cycle strobe becomes pending afterwards
        if (w_load) begin
            if (r_tx_pend) begin
                w_tx_shift_nx = r_tx_buf;
                w_tx_pend_nx  = 1'b0;
            end else begin
                w_tx_shift_nx = '0;
                w_ur_arm_nx   = 1'b1;
            end
        end
        if (data_latch) begin
            w_tx_buf_nx  = data_out;
            w_tx_pend_nx = 1'b1;
        end

        w_busy_nx = (w_state_nx == S_ACTIVE);
        w_miso_nx = w_busy_nx & w_tx_shift_nx[DATA_WIDTH-1];
    end

    // protocol and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= CNT_ZERO;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_tx_buf      <= '0;
            r_tx_pend     <= 1'b0;
            r_ur_arm      <= 1'b0;
            r_data_in     <= '0;
            r_data_rdy    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_busy        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_miso        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_bit_cnt     <= w_bit_cnt_nx;
            r_rx_shift    <= w_rx_shift_nx;
            r_tx_shift    <= w_tx_shift_nx;
            r_tx_buf      <= w_tx_buf_nx;
            r_tx_pend     <= w_tx_pend_nx;
            r_ur_arm      <= w_ur_arm_nx;
            r_data_in     <= w_data_in_nx;
            r_data_rdy    <= w_data_rdy_nx;
            r_tx_underrun <= w_tx_underrun_nx;
            r_busy        <= w_busy_nx;
            r_miso_oe     <= w_busy_nx;
            r_miso        <= w_miso_nx;
        end
    end

    assign data_in     = r_data_in;
    assign data_rdy    = r_data_rdy;
    assign tx_underrun = r_tx_underrun;
    assign busy        = r_busy;
    assign miso_oe     = r_miso_oe;
    assign miso        = r_miso;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a mode-0 host model at clk/8 drives frames,
// a monitor pops expected received bytes on every data_rdy pulse.
module tb_spi_target;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic          miso_oe;
    logic [DW-1:0] data_in;
    logic          data_rdy;
    logic [DW-1:0] data_out;
    logic          data_latch;
    logic          busy;
    logic          tx_underrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int ur_cnt = 0;
    logic [DW-1:0] exp_q [$];

    spi_target #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .data_in     (data_in),
        .data_rdy    (data_rdy),
        .data_out    (data_out),
        .data_latch  (data_latch),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor, sampling on the inactive edge
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (data_rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_data_rdy: got data_in 0x%0h, expected no pulse (t=%0t)",
                             data_in, $time);
                end else begin
                    check("data_in", 32'(data_in), 32'(exp_q.pop_front()));
                end
            end
            if (tx_underrun === 1'b1) ur_cnt++;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch_byte(input logic [DW-1:0] v);
        @(negedge clk);
        data_out   = v;
        data_latch = 1'b1;
        @(negedge clk);
        data_latch = 1'b0;
    endtask

    // host clocks nbits MSB first; optional strobe aligned to the 8th-rise load cycle
    task automatic xfer_bits(input logic [DW-1:0] tx, input int nbits, input bit latch_en,
                             input logic [DW-1:0] latch_val, output logic [DW-1:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[DW-1-i];
            wait_neg(4);
            rx   = {rx[DW-2:0], miso};
            sclk = 1'b1;
            if (latch_en && (i == nbits - 1)) begin
                wait_neg(2);
                data_out   = latch_val;
                data_latch = 1'b1;
                wait_neg(1);
                data_latch = 1'b0;
                wait_neg(1);
            end else begin
                wait_neg(4);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input logic [23:0] tx, input logic [23:0] exp_miso,
                             input bit latch_en, input logic [DW-1:0] latch_val, input int exp_ur,
                             input string tag);
        logic [DW-1:0] rx;
        int ur0;
        ur0  = ur_cnt;
        cs_n = 1'b0;
        wait_neg(8);
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        check({tag, "_oe_on"}, 32'(miso_oe), 32'd1);
        for (int k = 0; k < nbytes; k++) begin
            exp_q.push_back(tx[23-8*k -: 8]);
            xfer_bits(tx[23-8*k -: 8], 8, latch_en && (k == 0), latch_val, rx);
            check({tag, "_miso"}, 32'(rx), 32'(exp_miso[23-8*k -: 8]));
        end
        wait_neg(4);
        cs_n = 1'b1;
        wait_neg(8);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_oe_off"}, 32'(miso_oe), 32'd0);
        check({tag, "_miso_off"}, 32'(miso), 32'd0);
        check({tag, "_underruns"}, 32'(ur_cnt - ur0), 32'(exp_ur));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_in"}, 32'(data_in), 32'd0);
        check({tag, "_data_rdy"}, 32'(data_rdy), 32'd0);
        check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_miso"}, 32'(miso), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rx;
        int ur0;
        rst        = 1'b0;
        sclk       = 1'b0;
        cs_n       = 1'b1;
        mosi       = 1'b0;
        data_out   = '0;
        data_latch = 1'b0;
        wait_neg(3);
        check_reset_outputs("por");
        rst = 1'b1;
        wait_neg(5);

        // single byte with nothing pending: 0x00 on miso, one underrun
        run_frame(1, 24'hA5_0000, 24'h00_0000, 1'b0, 8'h00, 1, "rx_a5");

        // sclk activity while deselected changes nothing
        xfer_bits(8'hFF, 8, 1'b0, 8'h00, rx);
        wait_neg(4);
        check("idle_hold_data_in", 32'(data_in), 32'hA5);
        check("idle_busy", 32'(busy), 32'd0);

        latch_byte(8'h3C);
        run_frame(1, 24'hC6_0000, 24'h3C_0000, 1'b0, 8'h00, 0, "tx_3c");

        latch_byte(8'h55);
        run_frame(2, 24'h81_7E00, 24'h55_0000, 1'b0, 8'h00, 1, "two_byte");

        // aborted 5-bit frame, with a byte latched mid-frame that must survive
        ur0  = ur_cnt;
        cs_n = 1'b0;
        wait_neg(8);
        xfer_bits(8'hFF, 2, 1'b0, 8'h00, rx);
        latch_byte(8'h5A);
        xfer_bits(8'hFF, 3, 1'b0, 8'h00, rx);
        wait_neg(4);
        cs_n = 1'b1;
        wait_neg(8);
        check("abort_busy_off", 32'(busy), 32'd0);
        check("abort_underruns", 32'(ur_cnt - ur0), 32'd1);
        run_frame(1, 24'h0F_0000, 24'h5A_0000, 1'b0, 8'h00, 0, "after_abort");

        // latest latch wins; strobe coinciding with the byte-boundary load
        latch_byte(8'h77);
        latch_byte(8'hC3);
        run_frame(3, 24'h11_2244, 24'hC3_0096, 1'b1, 8'h96, 1, "latch_at_load");

        // reset mid-frame with cs_n held low
        cs_n = 1'b0;
        wait_neg(8);
        xfer_bits(8'hFF, 3, 1'b0, 8'h00, rx);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        wait_neg(3);
        rst = 1'b1;
        wait_neg(6);
        xfer_bits(8'h99, 8, 1'b0, 8'h00, rx);
        wait_neg(6);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_data_in", 32'(data_in), 32'd0);
        cs_n = 1'b1;
        wait_neg(8);
        run_frame(1, 24'h33_0000, 24'h00_0000, 1'b0, 8'h00, 1, "post_rst");

        wait_neg(10);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
